// File: rtl/aes_ctr_stream.sv
`timescale 1ns/1ps
// Purpose : CTR-mode stream wrapper around a fixed-latency, non-stallable AES-256 core.
// Latency : AES_LATENCY cycles from plaintext accept to FIFO write, +1 to out_valid.
// Backpr. : credit (in-flight + FIFO occupancy <= OUT_DEPTH) gates in_ready; out side is valid/ready.
//
// Ports: clk/rst_n (async active-low); cfg_* configuration latched on cfg_start;
//   busy/done status; in_valid/in_ready/in_data plaintext input; aes_state/aes_key
//   drive the core, aes_out is its keystream; out_valid/out_ready/out_data ciphertext.
// Optional macro AES_CTR_STREAM_STATS_EN adds stat_blocks / stat_stall counters.
module aes_ctr_stream #(
  parameter int AES_LATENCY = 15,
  parameter int OUT_DEPTH   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic [31:0]  cfg_num_blocks,
  output logic         busy,
  output logic         done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [127:0] aes_state,
  output logic [255:0] aes_key,
  input  logic [127:0] aes_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_CTR_STREAM_STATS_EN
  ,
  output logic [31:0]  stat_blocks,
  output logic [31:0]  stat_stall
`endif
);

  localparam int UW = $clog2(OUT_DEPTH + 1);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic [255:0]   key_q;
  logic [127:0]   ctr_q;
  logic [31:0]    remaining_q;
  logic [UW-1:0]  used_q, used_d;
  logic           start_acc, issue, pop, fifo_wr;
  logic [127:0]   fifo_wdat;

  // Delay line carrying {valid, plaintext} alongside the core pipeline.
  logic [AES_LATENCY-1:0]        dl_vld_q;
  logic [AES_LATENCY-1:0][127:0] dl_dat_q;

  // Output FIFO
  logic [127:0]   mem [OUT_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [UW-1:0]  cnt_q;

  assign start_acc = cfg_start && (state_q == IDLE);
  assign issue     = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign aes_state = ctr_q;
  assign aes_key   = key_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) state_d = (cfg_num_blocks != '0) ? RUN : DRAIN;
      end
      RUN: begin
        in_ready = (remaining_q != '0) && (used_q < UW'(OUT_DEPTH));
        // Leave one cycle after the last issue has been registered.
        if (remaining_q == '0) state_d = DRAIN;
      end
      DRAIN: if (used_q == '0) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- counter / key / credit ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      ctr_q       <= '0;
      remaining_q <= '0;
    end else if (start_acc) begin
      key_q       <= cfg_key;
      ctr_q       <= cfg_iv;
      remaining_q <= cfg_num_blocks;
    end else if (issue) begin
      ctr_q       <= ctr_q + 128'd1;
      remaining_q <= remaining_q - 32'd1;
    end
  end

  // used counts blocks issued but not yet popped: in the core plus in the FIFO.
  always_comb begin
    used_d = used_q;
    case ({issue, pop})
      2'b10:   used_d = used_q + UW'(1);
      2'b01:   used_d = used_q - UW'(1);
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) used_q <= '0;
    else        used_q <= used_d;
  end

  // ---------------- delay line ----------------
  // The core samples every cycle; non-issue cycles travel as invalid bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_q <= '0;
      dl_dat_q <= '0;
    end else begin
      dl_vld_q[0] <= issue;
      dl_dat_q[0] <= in_data;
      for (int i = 1; i < AES_LATENCY; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_dat_q[i] <= dl_dat_q[i-1];
      end
    end
  end

  assign fifo_wr   = dl_vld_q[AES_LATENCY-1];
  assign fifo_wdat = aes_out ^ dl_dat_q[AES_LATENCY-1];

  // ---------------- output FIFO ----------------
  // Credit guarantees room on every write, so there is no full check.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (fifo_wr) wptr_q <= ptr_inc(wptr_q);
      if (pop)     rptr_q <= ptr_inc(rptr_q);
      case ({fifo_wr, pop})
        2'b10:   cnt_q <= cnt_q + UW'(1);
        2'b01:   cnt_q <= cnt_q - UW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wptr_q] <= fifo_wdat;
  end

  assign out_valid = (cnt_q != '0);
  // Storage is not reset, so mask the head while empty to keep out_data at zero.
  assign out_data  = out_valid ? mem[rptr_q] : '0;

`ifdef AES_CTR_STREAM_STATS_EN
  logic [31:0] stat_blocks_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_blocks_q <= '0;
      stat_stall_q  <= '0;
    end else if (start_acc) begin
      stat_blocks_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (pop && (stat_blocks_q != '1)) stat_blocks_q <= stat_blocks_q + 32'd1;
      if ((state_q == RUN) && in_valid && !in_ready && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_blocks = stat_blocks_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_aes_ctr_stream.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for aes_ctr_stream with a behavioural AES-256 core model.
// Latency : core model is an AES_LATENCY-deep pipeline sampling aes_state every cycle.
// Backpr. : random in_valid/out_ready patterns plus a long out_ready=0 hold.
module tb_aes_ctr_stream;
  localparam int L = 15;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic [31:0]  cfg_num_blocks = '0;
  logic         busy, done;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] aes_state;
  logic [255:0] aes_key;
  logic [127:0] aes_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
`ifdef AES_CTR_STREAM_STATS_EN
  logic [31:0]  stat_blocks, stat_stall;
`endif

  always #5 clk = ~clk;

  aes_ctr_stream #(.AES_LATENCY(L), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .cfg_num_blocks(cfg_num_blocks), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .aes_state(aes_state), .aes_key(aes_key), .aes_out(aes_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef AES_CTR_STREAM_STATS_EN
    , .stat_blocks(stat_blocks), .stat_stall(stat_stall)
`endif
  );

  // ---------------- AES-256 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] blk, input logic [255:0] key);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = blk[127-8*k -: 8];
    for (int rnd = 0; rnd <= 14; rnd++) begin
      if (rnd > 0) begin
        for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
        for (int k = 0; k < 16; k++) s[k] = t[k];
        if (rnd < 14) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  // Core model: fixed-latency pipeline, never stalls, never reset.
  logic [127:0] core_pipe [L];
  assign aes_out = core_pipe[L-1];
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(aes_state, aes_key);
    for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] pt_q[$];
  logic [127:0] got_q[$];
  logic [127:0] st_q[$];
  int           done_cyc;

  // One message: per cycle, drive at negedge, sample 1 ns later, update the
  // model counters that take effect at the following posedge.
  task automatic run_msg(input logic [255:0] key, input logic [127:0] iv, input int n,
                         input int hold, input int vld_pct, input int rdy_pct,
                         input bit exact_done);
    int sent, popped, cyc, last_pop;
    bit done_seen, hold_prev;
    logic [127:0] prev_dat;
    sent = 0; popped = 0; cyc = 0; last_pop = -100;
    done_seen = 1'b0; hold_prev = 1'b0; prev_dat = '0;
    got_q.delete(); st_q.delete(); done_cyc = -1;
    @(negedge clk);
    cfg_key = key; cfg_iv = iv; cfg_num_blocks = n; cfg_start = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    @(negedge clk);
    cfg_start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      in_valid  = (sent < n) && ($urandom_range(99) < vld_pct);
      in_data   = (sent < n) ? pt_q[sent] : rand128();
      out_ready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
      #1;
      if (hold > 0 && cyc == hold) chk("bp_accepted", sent, (n < D) ? n : D);
      chk("in_ready", in_ready, (sent < n) && (sent - popped < D));
      if (hold_prev && out_valid) chk("hold_stable", out_data, prev_dat);
      if (in_valid && in_ready) begin
        chk("ctr_block", aes_state, iv + 128'(sent));
        if (sent == 0) chk("aes_key", aes_key, key);
        st_q.push_back(aes_state);
        sent++;
      end
      if (out_valid && out_ready) begin
        chk("ciphertext", out_data, pt_q[popped] ^ aes_enc(iv + 128'(popped), key));
        got_q.push_back(out_data);
        popped++;
        last_pop = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        chk("done_count", popped, n);
        chk("done_busy", busy, 1);
        if (exact_done) chk("done_latency", cyc - last_pop, 2);
      end
      hold_prev = out_valid && !out_ready;
      prev_dat  = out_data;
      cyc++;
      @(negedge clk);
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    in_valid = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_out_valid", out_valid, 0);
  endtask

  task automatic fill_rand(input int n);
    pt_q.delete();
    for (int i = 0; i < n; i++) pt_q.push_back(rand128());
  endtask

  localparam logic [255:0] KAT_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KAT_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  logic [127:0] kat_pt [4];
  logic [127:0] kat_ct [4];

  initial begin
    kat_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    kat_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    kat_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    kat_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    kat_ct[0] = 128'h601ec313775789a5b7a7f504bbf3d228;
    kat_ct[1] = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
    kat_ct[2] = 128'h2b0930daa23de94ce87017ba2d84988d;
    kat_ct[3] = 128'hdfc9c58db67aada613c2dd08457941a6;

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aes_state", aes_state, 0);
    chk("rst_aes_key", aes_key, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single-block known answer
    pt_q.delete(); pt_q.push_back(kat_pt[0]);
    run_msg(KAT_KEY, KAT_IV, 1, 0, 100, 100, 1'b1);
    chk("kat1_ct", (got_q.size() > 0) ? got_q[0] : '0, kat_ct[0]);

    // Four blocks back-to-back
    pt_q.delete();
    for (int i = 0; i < 4; i++) pt_q.push_back(kat_pt[i]);
    run_msg(KAT_KEY, KAT_IV, 4, 0, 100, 100, 1'b1);
    for (int i = 0; i < 4; i++)
      chk("kat4_ct", (got_q.size() > i) ? got_q[i] : '0, kat_ct[i]);
    chk("kat4_ctr2", (st_q.size() > 1) ? st_q[1] : '0, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);

    // Backpressure: sink held off, 100 blocks offered
    fill_rand(100);
    run_msg({rand128(), rand128()}, rand128(), 100, 80, 100, 100, 1'b0);
    chk("bp_count", got_q.size(), 100);

    // Empty message
    pt_q.delete();
    run_msg({rand128(), rand128()}, rand128(), 0, 0, 100, 100, 1'b0);
    chk("empty_done_within3", (done_cyc >= 0) && (done_cyc <= 2), 1);
    chk("empty_no_output", got_q.size(), 0);

    // Counter wrap
    fill_rand(2);
    run_msg({rand128(), rand128()}, {128{1'b1}}, 2, 0, 100, 100, 1'b1);
    chk("wrap_ctr2", (st_q.size() > 1) ? st_q[1] : '1, 128'h0);

    // Random traffic
    for (int m = 0; m < 4; m++) begin
      int n;
      n = $urandom_range(40, 5);
      fill_rand(n);
      run_msg({rand128(), rand128()}, rand128(), n, 0, 70, 60, 1'b0);
    end

    // Mid-run reset with 10 blocks in flight
    fill_rand(10);
    @(negedge clk);
    cfg_key = {rand128(), rand128()}; cfg_iv = rand128(); cfg_num_blocks = 10;
    cfg_start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data  = pt_q[(c < 10) ? c : 9];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      chk("mrst_no_stale", out_valid, 0);
      @(negedge clk);
    end

    // Clean message after reset
    fill_rand(6);
    run_msg({rand128(), rand128()}, rand128(), 6, 0, 80, 80, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
